// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush sequencer.
// The PIPE_CTRL_DIV_EN build option selects the divide wait counter.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned PIPE_PC_W = 32;
    localparam int unsigned DIV_CNT_W = 8;

    // Level of rst_n that holds the block in reset
    localparam logic RST_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_div_wait_cnt.sv
// EX divide wait counter: holds the divide for DIV_CYCLES cycles, then raises done.
// Present only when PIPE_CTRL_DIV_EN is defined.
`ifdef PIPE_CTRL_DIV_EN
module div_wait_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic flush,
    input  logic leave,
    output logic busy,
    output logic done
);

    logic [DIV_CNT_W-1:0] cnt;

    // done is raised on the 1->0 step and held until EX hands the divide on
    always_ff @(posedge clk) begin
        if (rst_n == RST_LEVEL) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (flush) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            cnt <= DIV_CNT_W'(DIV_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_CNT_W'(1);
            if (cnt == DIV_CNT_W'(1)) begin
                done <= 1'b1;
            end
        end else if (leave) begin
            done <= 1'b0;
        end
    end

    assign busy = (cnt != '0);

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: allowin/valid chain, load-use and divide stalls,
// WB exception/ertn flush and fetch redirect. Define PIPE_CTRL_DIV_EN for the divide counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned PC_W       = PIPE_PC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid_i,
    input  logic                 id_valid_i,
    input  logic                 ex_valid_i,
    input  logic                 mem_valid_i,
    input  logic                 wb_valid_i,
    input  logic                 if_ready_go_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic                 ex_load_i,
    input  logic                 ex_we_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_div_i,
    input  logic                 mem_wait_i,
    input  logic                 mem_data_ok_i,
    input  logic                 wb_excp_i,
    input  logic                 wb_ertn_i,
    input  logic [PC_W-1:0]      wb_target_i,
    input  logic                 if_fetch_ok_i,
    output logic                 if_allowin_o,
    output logic                 id_allowin_o,
    output logic                 ex_allowin_o,
    output logic                 mem_allowin_o,
    output logic                 wb_allowin_o,
    output logic                 if_to_id_valid_o,
    output logic                 id_to_ex_valid_o,
    output logic                 ex_to_mem_valid_o,
    output logic                 mem_to_wb_valid_o,
    output logic                 flush_o,
    output logic                 redirect_valid_o,
    output logic [PC_W-1:0]      redirect_pc_o,
    output logic                 div_busy_o
);

    ctrl_state_e state, state_next;
    logic        trig;
    logic        if_rg, id_rg, ex_rg, mem_rg;
    logic        rs1_hit, rs2_hit, load_use;

    // Load in EX whose result ID needs this cycle; r0 never creates a dependency
    assign rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign load_use = ex_valid_i && ex_load_i && ex_we_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

    assign if_rg  = if_ready_go_i;
    assign id_rg  = !load_use;
    assign mem_rg = !mem_wait_i || mem_data_ok_i;

`ifdef PIPE_CTRL_DIV_EN
    logic div_start, div_done;

    assign div_start = ex_valid_i && ex_div_i && !div_busy_o && !div_done && !flush_o;

    div_wait_cnt #(.DIV_CYCLES(DIV_CYCLES)) u_div_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .flush (flush_o),
        .leave (ex_allowin_o),
        .busy  (div_busy_o),
        .done  (div_done)
    );

    assign ex_rg = !ex_div_i || div_done;
`else
    logic unused_div;

    assign unused_div = ^{ex_div_i, DIV_CNT_W'(DIV_CYCLES)};
    assign ex_rg      = 1'b1;
    assign div_busy_o = 1'b0;
`endif

    // Allowin chain from WB back to IF; a flush opens every stage
    assign wb_allowin_o  = 1'b1;
    assign mem_allowin_o = flush_o || !mem_valid_i || (mem_rg && wb_allowin_o);
    assign ex_allowin_o  = flush_o || !ex_valid_i  || (ex_rg  && mem_allowin_o);
    assign id_allowin_o  = flush_o || !id_valid_i  || (id_rg  && ex_allowin_o);
    assign if_allowin_o  = flush_o || !if_valid_i  || (if_rg  && id_allowin_o);

    assign if_to_id_valid_o  = if_valid_i  && if_rg  && !flush_o && (state == ST_RUN);
    assign id_to_ex_valid_o  = id_valid_i  && id_rg  && !flush_o;
    assign ex_to_mem_valid_o = ex_valid_i  && ex_rg  && !flush_o;
    assign mem_to_wb_valid_o = mem_valid_i && mem_rg && !flush_o;

    always_ff @(posedge clk) begin
        if (rst_n == RST_LEVEL) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Flush is only honoured in RUN; a pending data response is drained first
    always_comb begin
        state_next = state;
        trig       = 1'b0;
        case (state)
            ST_RUN: begin
                trig = wb_valid_i && (wb_excp_i || wb_ertn_i);
                if (trig) begin
                    state_next = (mem_valid_i && mem_wait_i && !mem_data_ok_i) ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                if (mem_data_ok_i) begin
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (if_fetch_ok_i) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign flush_o = trig;

    always_ff @(posedge clk) begin
        if (rst_n == RST_LEVEL) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            redirect_valid_o <= (state_next == ST_REDIRECT);
            if (trig) begin
                redirect_pc_o <= wb_target_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed flush/drain/divide
// sequences and randomized cycles against a behavioural model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int unsigned DIV_CYCLES = 8;
    localparam int unsigned PC_W       = 32;
    localparam int          DIVC       = int'(DIV_CYCLES);
    localparam int          N_RAND     = 3000;
`ifdef PIPE_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid, id_valid, ex_valid, mem_valid, wb_valid;
    logic            if_ready_go;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_rs1_used, id_rs2_used, ex_load, ex_we, ex_div;
    logic            mem_wait, mem_data_ok, wb_excp, wb_ertn, if_fetch_ok;
    logic [PC_W-1:0] wb_target;
    logic            if_allowin, id_allowin, ex_allowin, mem_allowin, wb_allowin;
    logic            if_to_id_valid, id_to_ex_valid, ex_to_mem_valid, mem_to_wb_valid;
    logic            flush, redirect_valid, div_busy;
    logic [PC_W-1:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .PC_W(PC_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_valid_i        (if_valid),
        .id_valid_i        (id_valid),
        .ex_valid_i        (ex_valid),
        .mem_valid_i       (mem_valid),
        .wb_valid_i        (wb_valid),
        .if_ready_go_i     (if_ready_go),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_rs1_used_i     (id_rs1_used),
        .id_rs2_used_i     (id_rs2_used),
        .ex_load_i         (ex_load),
        .ex_we_i           (ex_we),
        .ex_rd_i           (ex_rd),
        .ex_div_i          (ex_div),
        .mem_wait_i        (mem_wait),
        .mem_data_ok_i     (mem_data_ok),
        .wb_excp_i         (wb_excp),
        .wb_ertn_i         (wb_ertn),
        .wb_target_i       (wb_target),
        .if_fetch_ok_i     (if_fetch_ok),
        .if_allowin_o      (if_allowin),
        .id_allowin_o      (id_allowin),
        .ex_allowin_o      (ex_allowin),
        .mem_allowin_o     (mem_allowin),
        .wb_allowin_o      (wb_allowin),
        .if_to_id_valid_o  (if_to_id_valid),
        .id_to_ex_valid_o  (id_to_ex_valid),
        .ex_to_mem_valid_o (ex_to_mem_valid),
        .mem_to_wb_valid_o (mem_to_wb_valid),
        .flush_o           (flush),
        .redirect_valid_o  (redirect_valid),
        .redirect_pc_o     (redirect_pc),
        .div_busy_o        (div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] v;       // {if, id, ex, mem, wb} valids
        logic       if_rg;
        logic [4:0] rs1, rs2;
        logic       u1, u2, ld, we;
        logic [4:0] rd;
        logic       mw, dok, excp;
        logic [4:0] e_allow; // {if, id, ex, mem, wb}
        logic [3:0] e_tov;   // {if_to_id, id_to_ex, ex_to_mem, mem_to_wb}
        logic       e_flush;
    } vec_t;

    vec_t tbl[14];

    // Behavioural model: 0=RUN 1=DRAIN 2=REDIRECT; m_el = cycles since divide start (0 idle)
    int              m_st;
    int              m_el;
    logic [PC_W-1:0] m_pc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] allow_vec();
        return {if_allowin, id_allowin, ex_allowin, mem_allowin, wb_allowin};
    endfunction

    function automatic logic [3:0] tov_vec();
        return {if_to_id_valid, id_to_ex_valid, ex_to_mem_valid, mem_to_wb_valid};
    endfunction

    task automatic idle();
        {if_valid, id_valid, ex_valid, mem_valid, wb_valid} = 5'b0;
        if_ready_go = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        {id_rs1_used, id_rs2_used, ex_load, ex_we, ex_div} = 5'b0;
        {mem_wait, mem_data_ok, wb_excp, wb_ertn, if_fetch_ok} = 5'b0;
        wb_target = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic u1, input logic u2, input logic exv,
                                     input logic ld, input logic we, input logic [4:0] rd);
        int reads[$];
        if (!(exv && ld && we) || rd == 5'd0) return 1'b0;
        if (u1) reads.push_back(int'(rs1));
        if (u2) reads.push_back(int'(rs2));
        foreach (reads[i]) if (reads[i] == int'(rd)) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every output against the model, then advance the model over the coming edge
    task automatic model_check_step();
        bit v[5], rg[5], al[5], tov[4];
        bit trig, done, busy;
        v     = '{if_valid, id_valid, ex_valid, mem_valid, wb_valid};
        done  = DIV_EN && (m_el == DIVC);
        busy  = DIV_EN && (m_el >= 1) && (m_el < DIVC);
        rg[0] = if_ready_go;
        rg[1] = !load_use(id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_load, ex_we, ex_rd);
        rg[2] = !DIV_EN || !ex_div || done;
        rg[3] = !mem_wait || mem_data_ok;
        rg[4] = 1'b1;
        trig  = (m_st == 0) && wb_valid && (wb_excp || wb_ertn);
        al[4] = 1'b1;
        for (int s = 3; s >= 0; s--) al[s] = !v[s] || (rg[s] && al[s+1]);
        if (trig) al = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int s = 0; s < 4; s++) tov[s] = v[s] && rg[s] && !trig;
        tov[0] = tov[0] && (m_st == 0);

        chk("rand_allowin", 64'(allow_vec()), 64'({al[0], al[1], al[2], al[3], al[4]}));
        chk("rand_to_valid", 64'(tov_vec()), 64'({tov[0], tov[1], tov[2], tov[3]}));
        chk("rand_flush", 64'(flush), 64'(trig));
        chk("rand_redirect_valid", 64'(redirect_valid), 64'(m_st == 2));
        chk("rand_redirect_pc", 64'(redirect_pc), 64'(m_pc));
        chk("rand_div_busy", 64'(div_busy), 64'(busy));

        if (!rst_n) begin
            m_st = 0; m_el = 0; m_pc = '0;
        end else begin
            case (m_st)
                0: if (trig) m_st = (mem_valid && mem_wait && !mem_data_ok) ? 1 : 2;
                1: if (mem_data_ok) m_st = 2;
                default: if (if_fetch_ok) m_st = 0;
            endcase
            if (trig) m_pc = wb_target;
            if (trig) m_el = 0;
            else if (m_el == 0) begin
                if (DIV_EN && ex_valid && ex_div) m_el = 1;
            end
            else if (m_el < DIVC) m_el++;
            else if (al[2]) m_el = 0;
        end
    endtask

    initial begin
        int first_go, busy_n;

        // v, if_rg, rs1, rs2, u1, u2, ld, we, rd, mw, dok, excp, e_allow, e_tov, e_flush
        tbl[0]  = '{5'b11111, 1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b11111, 4'b1111, 0};
        tbl[1]  = '{5'b11111, 1, 5'd5, 5'd2, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b00111, 4'b1011, 0};
        tbl[2]  = '{5'b11111, 1, 5'd1, 5'd5, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b00111, 4'b1011, 0};
        tbl[3]  = '{5'b11111, 1, 5'd1, 5'd5, 1, 0, 1, 1, 5'd5, 0, 0, 0, 5'b11111, 4'b1111, 0};
        tbl[4]  = '{5'b11111, 1, 5'd0, 5'd2, 1, 1, 1, 1, 5'd0, 0, 0, 0, 5'b11111, 4'b1111, 0};
        tbl[5]  = '{5'b11111, 1, 5'd5, 5'd2, 1, 1, 0, 1, 5'd5, 0, 0, 0, 5'b11111, 4'b1111, 0};
        tbl[6]  = '{5'b11111, 1, 5'd5, 5'd2, 1, 1, 1, 0, 5'd5, 0, 0, 0, 5'b11111, 4'b1111, 0};
        tbl[7]  = '{5'b11011, 1, 5'd5, 5'd2, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b11111, 4'b1101, 0};
        tbl[8]  = '{5'b11111, 1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5, 1, 0, 0, 5'b00001, 4'b1110, 0};
        tbl[9]  = '{5'b11111, 1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5, 1, 1, 0, 5'b11111, 4'b1111, 0};
        tbl[10] = '{5'b11111, 0, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b01111, 4'b0111, 0};
        tbl[11] = '{5'b00000, 1, 5'd5, 5'd2, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b11111, 4'b0000, 0};
        tbl[12] = '{5'b11111, 1, 5'd5, 5'd2, 1, 1, 1, 1, 5'd5, 1, 0, 1, 5'b11111, 4'b0000, 1};
        tbl[13] = '{5'b10111, 1, 5'd5, 5'd2, 1, 1, 1, 1, 5'd5, 0, 0, 0, 5'b11111, 4'b1011, 0};

        idle();
        rst_n = 1'b0;
        repeat (2) next_cycle();

        // Reset held: state stays RUN, so each vector is purely combinational
        foreach (tbl[i]) begin
            {if_valid, id_valid, ex_valid, mem_valid, wb_valid} = tbl[i].v;
            if_ready_go = tbl[i].if_rg;
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
            id_rs1_used = tbl[i].u1; id_rs2_used = tbl[i].u2;
            ex_load = tbl[i].ld; ex_we = tbl[i].we; ex_rd = tbl[i].rd;
            mem_wait = tbl[i].mw; mem_data_ok = tbl[i].dok; wb_excp = tbl[i].excp;
            @(negedge clk);
            chk($sformatf("vec%0d_allowin", i), 64'(allow_vec()), 64'(tbl[i].e_allow));
            chk($sformatf("vec%0d_to_valid", i), 64'(tov_vec()), 64'(tbl[i].e_tov));
            chk($sformatf("vec%0d_flush", i), 64'(flush), 64'(tbl[i].e_flush));
            next_cycle();
        end

        idle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_redirect_valid", 64'(redirect_valid), 64'(0));
        chk("reset_redirect_pc", 64'(redirect_pc), 64'(0));
        chk("reset_div_busy", 64'(div_busy), 64'(0));
        chk("reset_allowin", 64'(allow_vec()), 64'(5'b11111));
        chk("reset_to_valid", 64'(tov_vec()), 64'(4'b0000));
        chk("reset_flush", 64'(flush), 64'(0));

        // Exception with nothing pending in MEM, coinciding with a divide start
        next_cycle();
        {if_valid, id_valid, ex_valid, mem_valid, wb_valid} = 5'b11101;
        ex_div = 1'b1; wb_excp = 1'b1; wb_target = 32'h1C00_0000;
        @(negedge clk);
        chk("excp_flush", 64'(flush), 64'(1));
        chk("excp_allowin", 64'(allow_vec()), 64'(5'b11111));
        chk("excp_to_valid", 64'(tov_vec()), 64'(4'b0000));
        next_cycle();
        {if_valid, id_valid, ex_valid, mem_valid, wb_valid} = 5'b10001;
        ex_div = 1'b0; wb_target = 32'hDEAD_0000;
        @(negedge clk);
        chk("redir_flush_ignored", 64'(flush), 64'(0));
        chk("redir_valid", 64'(redirect_valid), 64'(1));
        chk("redir_pc", 64'(redirect_pc), 64'(32'h1C00_0000));
        chk("redir_div_idle", 64'(div_busy), 64'(0));
        chk("redir_if_gated", 64'(if_to_id_valid), 64'(0));
        next_cycle();
        wb_valid = 1'b0; wb_excp = 1'b0;
        @(negedge clk);
        chk("redir_hold", 64'(redirect_valid), 64'(1));
        next_cycle();
        if_fetch_ok = 1'b1;
        next_cycle();
        if_fetch_ok = 1'b0;
        @(negedge clk);
        chk("redir_release", 64'(redirect_valid), 64'(0));
        chk("run_if_to_id", 64'(if_to_id_valid), 64'(1));
        chk("run_pc_kept", 64'(redirect_pc), 64'(32'h1C00_0000));

        // ertn while MEM waits on data: drain first, second exception ignored
        next_cycle();
        idle();
        mem_valid = 1'b1; mem_wait = 1'b1; wb_valid = 1'b1; wb_ertn = 1'b1;
        wb_target = 32'h1C00_0800;
        @(negedge clk);
        chk("ertn_flush", 64'(flush), 64'(1));
        chk("ertn_mem_allowin", 64'(mem_allowin), 64'(1));
        next_cycle();
        mem_valid = 1'b0; wb_ertn = 1'b0; wb_excp = 1'b1; wb_target = 32'h0BAD_0000;
        @(negedge clk);
        chk("drain_flush_ignored", 64'(flush), 64'(0));
        chk("drain_no_redirect", 64'(redirect_valid), 64'(0));
        next_cycle();
        wb_valid = 1'b0; wb_excp = 1'b0; mem_data_ok = 1'b1;
        @(negedge clk);
        chk("drain_wait_ok", 64'(redirect_valid), 64'(0));
        next_cycle();
        mem_data_ok = 1'b0; mem_wait = 1'b0;
        @(negedge clk);
        chk("drain_to_redirect", 64'(redirect_valid), 64'(1));
        chk("drain_pc", 64'(redirect_pc), 64'(32'h1C00_0800));
        next_cycle();
        if_fetch_ok = 1'b1;
        next_cycle();
        if_fetch_ok = 1'b0;
        @(negedge clk);
        chk("drain_back_run", 64'(redirect_valid), 64'(0));

`ifdef PIPE_CTRL_DIV_EN
        // Divide residency, then a flush three cycles into a divide and a reset mid-redirect
        next_cycle();
        idle();
        ex_valid = 1'b1; ex_div = 1'b1;
        first_go = -1; busy_n = 0;
        for (int k = 0; k < 20 && first_go < 0; k++) begin
            @(negedge clk);
            if (div_busy) busy_n++;
            if (ex_to_mem_valid) first_go = k;
            next_cycle();
        end
        ex_valid = 1'b0; ex_div = 1'b0;
        chk("div_first_go", 64'(first_go), 64'(DIVC));
        chk("div_busy_cycles", 64'(busy_n), 64'(DIVC - 1));
        chk("div_residency", 64'(first_go + 1), 64'(DIVC + 1));
        @(negedge clk);
        chk("div_after_idle", 64'(div_busy), 64'(0));
        next_cycle();
        ex_valid = 1'b1; ex_div = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("div_mid_busy", 64'(div_busy), 64'(1));
        next_cycle();
        wb_valid = 1'b1; wb_excp = 1'b1; wb_target = 32'h1C00_0040;
        next_cycle();
        idle();
        @(negedge clk);
        chk("div_flush_clears", 64'(div_busy), 64'(0));
        chk("div_flush_redirect", 64'(redirect_valid), 64'(1));
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        ex_valid = 1'b1; ex_div = 1'b1; if_valid = 1'b1;
        @(negedge clk);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'(0));
        chk("rst_div_busy", 64'(div_busy), 64'(0));
        chk("rst_div_not_done", 64'(ex_to_mem_valid), 64'(0));
        chk("rst_state_run", 64'(if_to_id_valid), 64'(1));
`else
        next_cycle();
        idle();
        ex_valid = 1'b1; ex_div = 1'b1;
        @(negedge clk);
        chk("nodiv_ex_passes", 64'(ex_to_mem_valid), 64'(1));
        chk("nodiv_busy", 64'(div_busy), 64'(0));
        first_go = 0; busy_n = 0;
`endif

        // Randomized cycles against the model, starting from a clean reset
        next_cycle();
        idle();
        rst_n = 1'b0;
        next_cycle();
        m_st = 0; m_el = 0; m_pc = '0;
        for (int c = 0; c < N_RAND; c++) begin
            rst_n = ($urandom_range(199) != 0);
            {if_valid, id_valid, ex_valid, mem_valid} = 4'($urandom);
            wb_valid    = ($urandom_range(1) == 1);
            if_ready_go = ($urandom_range(3) != 0);
            id_rs1      = 5'($urandom_range(3));
            id_rs2      = 5'($urandom_range(3));
            ex_rd       = 5'($urandom_range(3));
            id_rs1_used = ($urandom_range(3) != 0);
            id_rs2_used = ($urandom_range(1) == 1);
            ex_load     = ($urandom_range(1) == 1);
            ex_we       = ($urandom_range(3) != 0);
            ex_div      = ($urandom_range(2) != 0);
            mem_wait    = ($urandom_range(2) == 0);
            mem_data_ok = ($urandom_range(2) == 0);
            wb_excp     = ($urandom_range(15) == 0);
            wb_ertn     = ($urandom_range(15) == 0);
            wb_target   = $urandom;
            if_fetch_ok = ($urandom_range(2) == 0);
            @(negedge clk);
            model_check_step();
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
